// File: rtl/arith_iq_pkg.sv
// Shared ALU reservation-station types: widths, entry layout, wakeup helpers.
// Also imported by rename/dispatch for the entry field layout.
package arith_iq_pkg;

  localparam int IQ_TAG_W  = 5;
  localparam int IQ_ROB_W  = 5;
  localparam int IQ_DATA_W = 8;
  localparam int IQ_OP_W   = 4;

  typedef struct packed {
    logic [IQ_TAG_W-1:0]  tag;
    logic                 rdy;
    logic [IQ_DATA_W-1:0] val;
  } iq_src_t;

  typedef struct packed {
    logic                 valid;
    logic [IQ_OP_W-1:0]   opcode;
    logic [IQ_OP_W-1:0]   imm;
    logic [IQ_ROB_W-1:0]  rob;
    logic [IQ_TAG_W-1:0]  dest;
    logic [IQ_TAG_W-1:0]  flag;
    logic [IQ_DATA_W-1:0] arch;
    iq_src_t              a;
    iq_src_t              b;
    iq_src_t              f;
  } iq_entry_t;

  function automatic iq_src_t iq_wake(
    input iq_src_t              s,
    input logic                 hit_en,
    input logic [IQ_TAG_W-1:0]  tag,
    input logic [IQ_DATA_W-1:0] val
  );
    iq_src_t r;
    r = s;
    if (hit_en && !s.rdy && s.tag == tag) begin
      r.rdy = 1'b1;
      r.val = val;
    end
    return r;
  endfunction

  function automatic iq_entry_t iq_wake_entry(
    input iq_entry_t            e,
    input logic                 cdb_valid,
    input logic [IQ_TAG_W-1:0]  dest,
    input logic [IQ_TAG_W-1:0]  flag,
    input logic [IQ_DATA_W-1:0] rval,
    input logic [IQ_DATA_W-1:0] rflags
  );
    iq_entry_t r;
    logic      en;
    r   = e;
    en  = cdb_valid & e.valid;
    r.a = iq_wake(e.a, en, dest, rval);
    r.b = iq_wake(e.b, en, dest, rval);
    r.f = iq_wake(e.f, en, flag, rflags);
    return r;
  endfunction

endpackage

// File: rtl/arith_iq_slot.sv
// One reservation-station entry: loads from dispatch or the slot above,
// and captures broadcast results for any source still waiting.
module arith_iq_slot
  import arith_iq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 load_disp,
  input  logic                 load_up,
  input  iq_entry_t            disp,
  input  iq_entry_t            up,
  input  logic                 cdb_valid,
  input  logic [IQ_TAG_W-1:0]  cdb_dest_reg,
  input  logic [IQ_TAG_W-1:0]  cdb_flag_reg,
  input  logic [IQ_DATA_W-1:0] cdb_result_val,
  input  logic [IQ_DATA_W-1:0] cdb_result_flags,
  output iq_entry_t            entry,
  output logic                 all_ready
);

  iq_entry_t src;

  always_comb begin
    src = entry;
    unique case (1'b1)
      load_disp: src = disp;
      load_up:   src = up;
      default:   src = entry;
    endcase
  end

  // Wakeup applies to the incoming value too, so a broadcast is never lost
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      entry <= '0;
    end else begin
      entry <= iq_wake_entry(src, cdb_valid, cdb_dest_reg,
                             cdb_flag_reg, cdb_result_val,
                             cdb_result_flags);
    end
  end

  assign all_ready = entry.valid & entry.a.rdy
                   & entry.b.rdy & entry.f.rdy;

endmodule

// File: rtl/arith_issue_queue.sv
// Age-ordered, compacting ALU issue queue feeding arithmetic_pipeline.
// Oldest ready entry issues each cycle; slots above it shift down.
module arith_issue_queue
  import arith_iq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = IQ_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [3:0]       disp_opcode,
  input  logic [3:0]       disp_immediate,
  input  logic [4:0]       disp_ROB_entry,
  input  logic [TAG_W-1:0] disp_dest_reg,
  input  logic [TAG_W-1:0] disp_flag_reg,
  input  logic [7:0]       disp_arch_dest_regs,
  input  logic [TAG_W-1:0] disp_a_tag,
  input  logic [TAG_W-1:0] disp_b_tag,
  input  logic [TAG_W-1:0] disp_f_tag,
  input  logic             disp_a_rdy,
  input  logic             disp_b_rdy,
  input  logic             disp_f_rdy,
  input  logic [7:0]       disp_a_val,
  input  logic [7:0]       disp_b_val,
  input  logic [7:0]       disp_f_val,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_dest_reg,
  input  logic [TAG_W-1:0] cdb_flag_reg,
  input  logic [7:0]       cdb_result_val,
  input  logic [7:0]       cdb_result_flags,
  output logic [3:0]       opcode,
  output logic [3:0]       immediate,
  output logic [4:0]       ROB_entry,
  output logic [TAG_W-1:0] dest_reg,
  output logic [TAG_W-1:0] flag_reg,
  output logic [7:0]       op_a_val,
  output logic [7:0]       op_b_val,
  output logic [7:0]       flags_val,
  output logic [7:0]       arch_dest_regs,
  output logic             instr_valid
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] count;
  iq_entry_t        ents [DEPTH];
  iq_entry_t        disp_ent;
  iq_entry_t        picked;
  logic [DEPTH-1:0] rdy_v, ld_disp, ld_up, clr;
  logic             disp_we, issue, found;
  int               sel;

  assign disp_ready = (count < CNT_W'(DEPTH));
  assign disp_we    = disp_valid & disp_ready & ~flush;
  assign issue      = found & ~flush;

  always_comb begin
    disp_ent        = '0;
    disp_ent.valid  = 1'b1;
    disp_ent.opcode = disp_opcode;
    disp_ent.imm    = disp_immediate;
    disp_ent.rob    = disp_ROB_entry;
    disp_ent.dest   = disp_dest_reg;
    disp_ent.flag   = disp_flag_reg;
    disp_ent.arch   = disp_arch_dest_regs;
    disp_ent.a      = '{disp_a_tag, disp_a_rdy, disp_a_val};
    disp_ent.b      = '{disp_b_tag, disp_b_rdy, disp_b_val};
    disp_ent.f      = '{disp_f_tag, disp_f_rdy, disp_f_val};
  end

  always_comb begin
    found  = 1'b0;
    sel    = 0;
    picked = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && rdy_v[i]) begin
        found  = 1'b1;
        sel    = i;
        picked = ents[i];
      end
    end
  end

  // Issue compacts slots >= sel; a same-cycle dispatch lands at count-1
  always_comb begin
    ld_disp = '0;
    ld_up   = '0;
    clr     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) begin
        clr[i] = 1'b1;
      end else if (issue && i >= sel) begin
        if (i == int'(count) - 1) begin
          ld_disp[i] = disp_we;
          clr[i]     = ~disp_we;
        end else if (i < int'(count) - 1) begin
          ld_up[i] = 1'b1;
        end
      end else if (disp_we && i == int'(count)) begin
        ld_disp[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    iq_entry_t up;
    if (g == DEPTH - 1) begin : g_top
      assign up = '0;
    end else begin : g_mid
      assign up = ents[g+1];
    end
    arith_iq_slot u_slot (
      .clk              (clk),
      .rst_n            (rst_n),
      .clear            (clr[g]),
      .load_disp        (ld_disp[g]),
      .load_up          (ld_up[g]),
      .disp             (disp_ent),
      .up               (up),
      .cdb_valid        (cdb_valid),
      .cdb_dest_reg     (cdb_dest_reg),
      .cdb_flag_reg     (cdb_flag_reg),
      .cdb_result_val   (cdb_result_val),
      .cdb_result_flags (cdb_result_flags),
      .entry            (ents[g]),
      .all_ready        (rdy_v[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(disp_we) - CNT_W'(issue);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opcode         <= '0;
      immediate      <= '0;
      ROB_entry      <= '0;
      dest_reg       <= '0;
      flag_reg       <= '0;
      op_a_val       <= '0;
      op_b_val       <= '0;
      flags_val      <= '0;
      arch_dest_regs <= '0;
      instr_valid    <= 1'b0;
    end else begin
      instr_valid <= issue;
      if (issue) begin
        opcode         <= picked.opcode;
        immediate      <= picked.imm;
        ROB_entry      <= picked.rob;
        dest_reg       <= picked.dest;
        flag_reg       <= picked.flag;
        op_a_val       <= picked.a.val;
        op_b_val       <= picked.b.val;
        flags_val      <= picked.f.val;
        arch_dest_regs <= picked.arch;
      end
    end
  end

endmodule

// File: doc/arith_issue_queue.md
Name: arith_issue_queue

Overview:
- Reservation station directly upstream of arithmetic_pipeline.
- Holds up to DEPTH dispatched ALU ops, captures missing operands/flags from the pipeline's result broadcast, and issues the oldest fully-ready op each cycle.
- Issue-side outputs drive arithmetic_pipeline inputs one-to-one; the wakeup bus is fed from arithmetic_pipeline registered outputs.

Parameters:
- DEPTH, 4, number of entries (2..8).
- TAG_W, 5, physical register tag width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discard all entries (branch mispredict).
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept.
- disp_opcode  in  4  ALU opcode.
- disp_immediate  in  4  immediate.
- disp_ROB_entry  in  5  ROB index.
- disp_dest_reg  in  TAG_W  physical value destination.
- disp_flag_reg  in  TAG_W  physical flags destination.
- disp_arch_dest_regs  in  8  architectural dest mask, passed through.
- disp_a_tag, disp_b_tag, disp_f_tag  in  TAG_W  source tags (A, B, flags).
- disp_a_rdy, disp_b_rdy, disp_f_rdy  in  1  source value already available.
- disp_a_val, disp_b_val, disp_f_val  in  8  source values, valid when the matching rdy is 1.
- cdb_valid  in  1  result broadcast valid (from output_valid).
- cdb_dest_reg  in  TAG_W  result tag.
- cdb_flag_reg  in  TAG_W  flags tag.
- cdb_result_val  in  8  result value.
- cdb_result_flags  in  8  result flags.
- opcode, immediate  out  4  to pipeline.
- ROB_entry, dest_reg, flag_reg  out  5  to pipeline.
- op_a_val, op_b_val, flags_val, arch_dest_regs  out  8  to pipeline.
- instr_valid  out  1  issued op valid.

Behaviour:
- Interface: single clock clk. rst_n is synchronous and active-low; it is sampled only on posedge clk.
- Reset: all entries invalid, count=0, and every output is registered 0. disp_ready=1 in the first cycle after reset.
- Storage is age-ordered and compacting:
  - slot 0 is the oldest entry; valid slots are contiguous from 0.
  - count is the number of valid slots.
- disp_ready = (count < DEPTH), combinational from registered count.
  - It does not account for a same-cycle issue; a full queue stalls one extra cycle.
- Dispatch: on disp_valid && disp_ready && !flush, the op is written to slot count, or to slot count-1 when an issue happens in the same cycle.
- Wakeup, evaluated every cycle for each valid, non-ready source:
  - A/B: if cdb_valid && tag==cdb_dest_reg, capture cdb_result_val and set rdy.
  - F: if cdb_valid && tag==cdb_flag_reg, capture cdb_result_flags and set rdy.
  - Already-ready sources are never overwritten.
- Dispatch bypass: the same compare is applied to incoming disp_* sources with rdy=0 in the dispatch cycle, so a broadcast coinciding with dispatch is not lost.
- Select:
  - Candidates are entries whose registered a_rdy&b_rdy&f_rdy=1; the lowest-index candidate issues.
  - An entry woken in cycle N is first selectable in cycle N+1.
  - An entry dispatched fully ready is selectable the cycle after dispatch.
- Issue:
  - Selected entry fields are registered onto the outputs with instr_valid=1 on the next edge.
  - The entry is removed, and slots above it shift down by one, preserving order.
  - If no candidate, instr_valid=0 and the other outputs hold their last values.
  - Minimum latency: dispatch-ready at edge N, instr_valid at edge N+2.
- Throughput: at most one issue and one dispatch per cycle, concurrently.
- Flush:
  - All entries are invalidated and count=0 on the next edge.
  - instr_valid=0 on that edge.
  - Dispatch and wakeup in the flush cycle are ignored.
- Reset mid-operation has the same effect as flush, plus all outputs are zeroed.
- Tag 0 has no special meaning; it matches like any other tag.

Decomposition:
- Shared header/package (also used by rename/dispatch):
  - TAG_W, ROB index width 5, data width 8, opcode width 4.
  - The entry field layout (valid, opcode, imm, ROB, dest, flag, arch mask, three {tag, rdy, val} sources).
- One natural sub-module, arith_iq_slot: one entry register.
  - Inputs: load-from-dispatch, load-from-upper-slot (shift), clear.
  - Contains its own wakeup comparators.
  - Outputs: all_ready and its fields.
- Top level holds count, the lowest-index priority select, and the output registers.

Test Plan:
- Reset with rst_n=0 for 2 cycles while disp_valid=1 -> instr_valid=0, all outputs 0, count stays 0; after release disp_ready=1.
- Dispatch opcode=3, a_val=0x12, b_val=0x34, f_val=0x01, all rdy=1, ROB=7 at edge N -> instr_valid=1 at edge N+2 with op_a_val=0x12, op_b_val=0x34, ROB_entry=7.
- Dispatch op X with b_tag=9, b_rdy=0; broadcast cdb_dest_reg=9, result_val=0xAB two cycles later -> X issues the cycle after the wakeup, with op_b_val=0xAB; no earlier issue.
- Dispatch Y (b_tag=9, b_rdy=0) in the same cycle as cdb_dest_reg=9, result 0x5C -> bypass captures it; Y issues two edges later with op_b_val=0x5C.
- Fill 4 entries with the oldest blocked on tag 4 and the other three ready -> the three issue in dispatch order, disp_ready=0 only while count=4, the blocked entry issues after cdb_dest_reg=4, and a 5th dispatch is accepted once count<4.
- With 3 valid entries, assert flush concurrently with disp_valid and a matching cdb -> next cycle count=0, instr_valid=0, no later issue of any flushed op.
